// File: rtl/hid_event_encoder.sv
// hid_event_encoder: gamepad HID report -> press/release event queue.
// Decodes a d-pad (from two axis bytes) and a button field into a state
// vector, diffs successive vectors bit by bit and queues one event per
// changed bit in a first-word-fall-through FIFO. A report timeout marks
// the link as lost and synthesizes an all-zero report ("release all").
//
// Ports:
//   clk_i, rstn_i     clock (clk_usb), synchronous active-low reset
//   hid_report        raw report, byte k = hid_report[8k+7:8k]
//   hid_valid         one-cycle report strobe
//   state_o           last accepted vector {btn,down,up,right,left}
//   connected_o       link up (set by a report, cleared by timeout)
//   ev_valid_o        event FIFO not empty
//   ev_ready_i        consumer pop strobe (with ev_valid_o)
//   ev_data_o         {press,idx[7:0]} or {ts[15:0],press,idx[7:0]}
//   overflow_o        sticky, an event was dropped on a full FIFO
//   drop_count_o      dropped-event count, saturating at 255
//
// Build option: define HID_EVENT_TIMESTAMP_EN to add a 16-bit free-running
// cycle stamp to every event (ev_data_o becomes 25 bits wide).
module hid_event_encoder #(
    parameter int         C_report_bytes = 8,
    parameter int         C_x_byte       = 0,
    parameter int         C_y_byte       = 1,
    parameter int         C_btn_byte     = 5,
    parameter int         C_btn_bits     = 16,
    parameter logic [7:0] C_axis_lo      = 8'h40,
    parameter logic [7:0] C_axis_hi      = 8'hC0,
    parameter int         C_fifo_depth   = 8,
    parameter int         C_timeout      = 6000000
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [8*C_report_bytes-1:0] hid_report,
    input  logic                        hid_valid,
    output logic [C_btn_bits+3:0]       state_o,
    output logic                        connected_o,
    output logic                        ev_valid_o,
    input  logic                        ev_ready_i,
`ifdef HID_EVENT_TIMESTAMP_EN
    output logic [24:0]                 ev_data_o,
`else
    output logic [8:0]                  ev_data_o,
`endif
    output logic                        overflow_o,
    output logic [7:0]                  drop_count_o
);

    localparam int W  = C_btn_bits + 4;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int AW = (C_fifo_depth > 2) ? $clog2(C_fifo_depth) : 1;
    localparam int TW = $clog2(C_timeout + 1);
`ifdef HID_EVENT_TIMESTAMP_EN
    localparam int EVW = 25;
`else
    localparam int EVW = 9;
`endif

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t          state_r;
    state_t          state_n;

    logic [7:0]      x_axis;
    logic [7:0]      y_axis;
    logic [W-1:0]    rep_vec;
    logic            unused_bits;

    logic [W-1:0]    prev_r;
    logic [W-1:0]    cur_r;
    logic [W-1:0]    pend_r;
    logic            pend_v;
    logic [IW-1:0]   idx_r;

    logic            load_go;
    logic [W-1:0]    load_vec;
    logic            scan_last;
    logic            scan_push;
    logic [8:0]      push_data;

    logic [TW-1:0]   tmo_r;
    logic            expire;

    logic [EVW-1:0]  mem [C_fifo_depth];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt_r;
    logic            full;
    logic            do_push;
    logic            do_pop;
    logic            drop;
    logic [EVW-1:0]  ev_in;

    // Report decode; axes are unsigned, centre band is inclusive of lo/hi.
    always_comb begin
        x_axis  = hid_report[8*C_x_byte +: 8];
        y_axis  = hid_report[8*C_y_byte +: 8];
        rep_vec = {hid_report[8*C_btn_byte +: C_btn_bits],
                   y_axis > C_axis_hi,
                   y_axis < C_axis_lo,
                   x_axis > C_axis_hi,
                   x_axis < C_axis_lo};
    end

    // Reduction of the whole report keeps the bytes we ignore visibly consumed.
    assign unused_bits = ^hid_report;

    // Timeout only fires when no report arrives in the same cycle.
    assign expire = connected_o && !hid_valid &&
                    (tmo_r == TW'(C_timeout - 1));

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM: next state
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            S_IDLE: begin
                if (load_go && (load_vec != prev_r)) begin
                    state_n = S_SCAN;
                end
            end
            S_SCAN: begin
                if (scan_last) begin
                    state_n = S_IDLE;
                end
            end
        endcase
    end

    // FSM: outputs; a held pending report takes priority over a new strobe.
    always_comb begin
        load_go   = 1'b0;
        load_vec  = pend_v ? pend_r : rep_vec;
        scan_last = 1'b0;
        scan_push = 1'b0;
        push_data = {cur_r[idx_r], 8'(idx_r)};
        unique case (state_r)
            S_IDLE: begin
                load_go = pend_v || hid_valid;
            end
            S_SCAN: begin
                scan_last = (idx_r == IW'(W - 1));
                scan_push = cur_r[idx_r] ^ prev_r[idx_r];
            end
        endcase
    end

    // Vector, scan index and pending-report registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            prev_r  <= '0;
            cur_r   <= '0;
            pend_r  <= '0;
            pend_v  <= 1'b0;
            idx_r   <= '0;
            state_o <= '0;
        end else begin
            if (load_go) begin
                cur_r   <= load_vec;
                state_o <= load_vec;
            end
            if (state_r == S_SCAN) begin
                idx_r <= scan_last ? '0 : idx_r + IW'(1);
            end
            if (scan_last) begin
                prev_r <= cur_r;
            end
            // Strobes arriving mid-scan coalesce into one pending slot.
            if ((state_r == S_SCAN) && hid_valid) begin
                pend_r <= rep_vec;
                pend_v <= 1'b1;
            end else if (load_go && pend_v) begin
                if (hid_valid) begin
                    pend_r <= rep_vec;
                end else begin
                    pend_v <= 1'b0;
                end
            end
            // Link loss: queue an all-released report behind any scan.
            if (expire) begin
                pend_r <= '0;
                pend_v <= 1'b1;
            end
        end
    end

    // Link supervision.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            tmo_r       <= '0;
            connected_o <= 1'b0;
        end else if (hid_valid) begin
            tmo_r       <= '0;
            connected_o <= 1'b1;
        end else if (connected_o) begin
            if (expire) begin
                tmo_r       <= '0;
                connected_o <= 1'b0;
            end else begin
                tmo_r <= tmo_r + TW'(1);
            end
        end
    end

`ifdef HID_EVENT_TIMESTAMP_EN
    logic [15:0] ts_r;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + 16'd1;
        end
    end

    assign ev_in = {ts_r, push_data};
`else
    assign ev_in = push_data;
`endif

    // Event FIFO, first-word-fall-through. A pop frees a slot in the same
    // cycle, so a push on a full FIFO still lands when the consumer pops.
    assign full       = (cnt_r == (AW+1)'(C_fifo_depth));
    assign ev_valid_o = (cnt_r != '0);
    assign ev_data_o  = mem[rd_ptr];
    assign do_pop     = ev_valid_o && ev_ready_i;
    assign do_push    = scan_push && (!full || do_pop);
    assign drop       = scan_push && full && !do_pop;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < C_fifo_depth; i++) begin
                mem[i] <= '0;
            end
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt_r        <= '0;
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= ev_in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt_r <= cnt_r + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_count_o != 8'hFF) begin
                    drop_count_o <= drop_count_o + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hid_event_encoder.sv
// tb_hid_event_encoder: scoreboard bench for hid_event_encoder.
// Directed scenarios plus randomized reports against a behavioural model.
module tb_hid_event_encoder;

    localparam int W   = 20;
    localparam int TMO = 400;
`ifdef HID_EVENT_TIMESTAMP_EN
    localparam int EVW = 25;
`else
    localparam int EVW = 9;
`endif

    logic           clk = 1'b0;
    logic           rstn;
    logic [63:0]    hid_report;
    logic           hid_valid;
    logic [W-1:0]   state_o;
    logic           connected_o;
    logic           ev_valid_o;
    logic           ev_ready_i;
    logic [EVW-1:0] ev_data_o;
    logic           overflow_o;
    logic [7:0]     drop_count_o;

    int             checks = 0;
    int             errors = 0;
    logic [8:0]     exp_q[$];
    logic [EVW-1:0] got_q[$];
    logic [W-1:0]   model_prev;
    int             model_drops;
    logic           rand_ready = 1'b0;
    logic [8:0]     mon_e;

    hid_event_encoder #(
        .C_timeout(TMO)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .hid_report  (hid_report),
        .hid_valid   (hid_valid),
        .state_o     (state_o),
        .connected_o (connected_o),
        .ev_valid_o  (ev_valid_o),
        .ev_ready_i  (ev_ready_i),
        .ev_data_o   (ev_data_o),
        .overflow_o  (overflow_o),
        .drop_count_o(drop_count_o)
    );

    always #5 clk = ~clk;

    // Reference decode straight from the report rules.
    function automatic logic [W-1:0] decode(input logic [63:0] r);
        int x;
        int y;
        logic [W-1:0] v;
        x = int'(r[7:0]);
        y = int'(r[15:8]);
        v = '0;
        v[0] = (x < 64);
        v[1] = (x > 192);
        v[2] = (y < 64);
        v[3] = (y > 192);
        v[W-1:4] = r[55:40];
        return v;
    endfunction

    function automatic logic [63:0] mkrep(input logic [7:0] x,
                                          input logic [7:0] y,
                                          input logic [15:0] b);
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[7:0]   = x;
        r[15:8]  = y;
        r[55:40] = b;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected events for a newly applied vector; room = free FIFO slots
    // while the consumer is stalled, surplus events are drops.
    task automatic expect_report(input logic [W-1:0] v, input int room);
        int left;
        left = room;
        for (int i = 0; i < W; i++) begin
            if (v[i] != model_prev[i]) begin
                if (left > 0) begin
                    exp_q.push_back({v[i], 8'(i)});
                    left--;
                end else if (model_drops < 255) begin
                    model_drops++;
                end
            end
        end
        model_prev = v;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [63:0] r);
        @(posedge clk);
        #1;
        hid_report = r;
        hid_valid  = 1'b1;
        @(posedge clk);
        #1;
        hid_valid  = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: every accepted event is matched against the scoreboard.
    always @(negedge clk) begin
        if (rstn && ev_valid_o && ev_ready_i) begin
            checks++;
            got_q.push_back(ev_data_o);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ev_unexpected got %0h expected none",
                         ev_data_o[8:0]);
            end else begin
                mon_e = exp_q.pop_front();
                if (ev_data_o[8:0] !== mon_e) begin
                    errors++;
                    $display("FAIL ev_data got %0h expected %0h",
                             ev_data_o[8:0], mon_e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                ev_ready_i = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [63:0] ra;
        logic [63:0] rc;
        logic [7:0]  bx[4];
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] m;
        int          n0;

        bx[0] = 8'h3F;
        bx[1] = 8'h40;
        bx[2] = 8'hC0;
        bx[3] = 8'hC1;
        model_prev  = '0;
        model_drops = 0;
        rstn        = 1'b0;
        hid_valid   = 1'b0;
        hid_report  = '0;
        ev_ready_i  = 1'b1;
        tick(3);
        check("rst_state", state_o, 0);
        check("rst_conn", connected_o, 0);
        check("rst_evv", ev_valid_o, 0);
        check("rst_data", ev_data_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_drop", drop_count_o, 0);
        rstn = 1'b1;
        tick(2);

        // Neutral report: no events, link comes up.
        r = mkrep(8'h80, 8'h80, 16'h0000);
        expect_report(decode(r), 99);
        send(r);
        check("t1_conn", connected_o, 1);
        check("t1_state", state_o, 0);
        tick(25);
        check("t1_noev", ev_valid_o, 0);

        // Button 0 press: event idx 4 visible after the 5th edge.
        r = mkrep(8'h80, 8'h80, 16'h0001);
        expect_report(decode(r), 99);
        send(r);
        tick(4);
        check("t2_lat_early", ev_valid_o, 0);
        tick(1);
        check("t2_lat", ev_valid_o, 1);
        check("t2_state", state_o, 20'h10);
        tick(20);
        r = mkrep(8'h80, 8'h80, 16'h0000);
        expect_report(decode(r), 99);
        send(r);
        tick(25);
        wait_drain("t2_drain", 50);

        // Left + down in one report, ascending idx order.
        n0 = got_q.size();
        r = mkrep(8'h00, 8'hFF, 16'h0000);
        expect_report(decode(r), 99);
        send(r);
        tick(25);
        check("t3_dpad", state_o[3:0], 4'b1001);
        wait_drain("t3_drain", 50);
        check("t3_count", got_q.size() - n0, 2);
`ifdef HID_EVENT_TIMESTAMP_EN
        if (got_q.size() - n0 == 2) begin
            logic [15:0] d;
            d = got_q[n0+1][24:9] - got_q[n0][24:9];
            check("t7_ts_gap", d, 3);
        end
`endif
        r = mkrep(8'h80, 8'h80, 16'h0000);
        expect_report(decode(r), 99);
        send(r);
        tick(25);
        wait_drain("t3_back", 50);

        // Overflow: stalled consumer, 10 presses into 8 slots.
        ev_ready_i = 1'b0;
        r = mkrep(8'h80, 8'h80, 16'h03FF);
        expect_report(decode(r), 8);
        send(r);
        tick(25);
        check("t4_ovf", overflow_o, 1);
        check("t4_drop", drop_count_o, model_drops);
        check("t4_drop2", drop_count_o, 2);
        check("t4_evv", ev_valid_o, 1);
        ev_ready_i = 1'b1;
        wait_drain("t4_drain", 50);
        r = mkrep(8'h80, 8'h80, 16'h0000);
        expect_report(decode(r), 99);
        send(r);
        tick(25);
        wait_drain("t4_rel", 50);

        // Coalescing: B is overwritten by C while A scans.
        ra = mkrep(8'h00, 8'h80, 16'h0005);
        rc = mkrep(8'h80, 8'h80, 16'h0006);
        expect_report(decode(ra), 99);
        send(ra);
        tick(1);
        send(mkrep(8'hFF, 8'h80, 16'hFFFF));
        tick(1);
        send(rc);
        expect_report(decode(rc), 99);
        tick(45);
        check("t5_state", state_o, decode(rc));
        wait_drain("t5_drain", 50);
        check("t5_noev", ev_valid_o, 0);

        // Randomized reports, at most 8 changed bits each.
        rand_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) x = bx[$urandom_range(0, 3)];
            else x = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) y = bx[$urandom_range(0, 3)];
            else y = 8'($urandom_range(0, 255));
            m = '0;
            repeat ($urandom_range(0, 4)) m[$urandom_range(0, 15)] = 1'b1;
            r = mkrep(x, y, model_prev[W-1:4] ^ m);
            expect_report(decode(r), 8);
            send(r);
            tick($urandom_range(24, 40));
            check("rnd_state", state_o, model_prev);
            wait_drain("rnd_drain", 200);
        end
        rand_ready = 1'b0;
        ev_ready_i = 1'b1;

        // Timeout: held button 2 is released by the link-loss report.
        r = mkrep(8'h80, 8'h80, 16'h0004);
        expect_report(decode(r), 99);
        send(r);
        tick(25);
        wait_drain("t6_pre", 60);
        send(r);
        expect_report('0, 99);
        check("t6_one", exp_q.size(), 1);
        tick(TMO - 1);
        check("t6_conn_hold", connected_o, 1);
        tick(1);
        check("t6_conn_lost", connected_o, 0);
        tick(30);
        check("t6_state", state_o, 0);
        wait_drain("t6_drain", 50);

        check("end_ovf", overflow_o, 1);
        check("end_drop", drop_count_o, model_drops);
        check("end_evv", ev_valid_o, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
